// File: rtl/ndp_pkg.sv
// ndp_pkg
//   Shared definitions for the NDP result path: the drain FSM state encoding
//   and a clog2 helper that never returns a zero width.
package ndp_pkg;

    typedef enum logic [0:0] {
        NDP_DRAIN_IDLE  = 1'b0,
        NDP_DRAIN_DRAIN = 1'b1
    } ndp_drain_state_e;

    // Width needed to index n items, never less than one bit so that
    // degenerate sizes still produce legal vector declarations.
    function automatic int ndp_clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ndp_beat_mux.sv
// ndp_beat_mux
//   Selects one output beat out of the captured result bank. Because the bank
//   is row-major and a row holds a whole number of beats, beat b is simply
//   the b-th BEAT_ELEMS*WIDTH slice of the flat bank.
//
// Ports
//   bank     in   TOTAL*BEAT_ELEMS*WIDTH  captured result matrix
//   beat_idx in   clog2(TOTAL), min 1     beat to present
//   slice    out  BEAT_ELEMS*WIDTH        selected beat, element 0 in LSBs
module ndp_beat_mux
    import ndp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int BEAT_ELEMS = 16,
    parameter int TOTAL      = 64
) (
    input  logic [TOTAL*BEAT_ELEMS*WIDTH-1:0]        bank,
    input  logic [ndp_clog2_min1(TOTAL)-1:0]         beat_idx,
    output logic [BEAT_ELEMS*WIDTH-1:0]              slice
);

    localparam int BEAT_W = BEAT_ELEMS * WIDTH;
    localparam int CNT_W  = ndp_clog2_min1(TOTAL);

    // Explicit compare-and-select keeps out-of-range indices (possible when
    // TOTAL is not a power of two) from reading past the bank.
    always_comb begin
        slice = '0;
        for (int i = 0; i < TOTAL; i++) begin
            if (beat_idx == CNT_W'(i)) begin
                slice = bank[i*BEAT_W +: BEAT_W];
            end
        end
    end

endmodule

// File: rtl/ndp_result_drain.sv
// ndp_result_drain
//   Captures the NDP result matrix on the rising edge of calc_done_flag and
//   streams it out row-major, BEAT_ELEMS elements per beat. After the final
//   beat is accepted a one-cycle ndp_clear pulse lets the array start the
//   next tile. A rise that arrives while a drain is in progress is dropped
//   and recorded in the sticky err_overflow flag.
//
// Ports
//   clk, reset (async, active-low)
//   calc_done_flag  in   level; only its rising edge starts a drain
//   in_c            in   ROWS*COLS*WIDTH result matrix, (r,c) at (r*COLS+c)*WIDTH
//   out_valid/out_ready/out_data/out_row/out_col_beat/out_last   beat stream
//   busy            out  high while draining
//   ndp_clear       out  one-cycle clear request after the last beat
//   err_overflow    out  sticky dropped-result flag
//   dbg_state       out  current FSM state encoding
module ndp_result_drain
    import ndp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ROWS       = 4,
    parameter int COLS       = 256,
    parameter int BEAT_ELEMS = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      calc_done_flag,
    input  logic [ROWS*COLS*WIDTH-1:0]                in_c,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [BEAT_ELEMS*WIDTH-1:0]               out_data,
    output logic [ndp_clog2_min1(ROWS)-1:0]           out_row,
    output logic [ndp_clog2_min1(COLS/BEAT_ELEMS)-1:0] out_col_beat,
    output logic                                      out_last,
    output logic                                      busy,
    output logic                                      ndp_clear,
    output logic                                      err_overflow,
    output logic [0:0]                                dbg_state
);

    localparam int BPR   = COLS / BEAT_ELEMS;
    localparam int TOTAL = ROWS * BPR;
    localparam int CNT_W = ndp_clog2_min1(TOTAL);
    localparam int ROW_W = ndp_clog2_min1(ROWS);
    localparam int CB_W  = ndp_clog2_min1(BPR);
    localparam logic [CNT_W-1:0] LAST_B = CNT_W'(TOTAL - 1);

    if (COLS % BEAT_ELEMS != 0) begin : g_bad_cfg
        $error("ndp_result_drain: BEAT_ELEMS must divide COLS");
    end

    ndp_drain_state_e                  state_q, state_d;
    logic [CNT_W-1:0]                  b_q, b_d;
    logic                              flag_q;
    logic                              clear_q;
    logic                              err_q;
    logic                              rise;
    logic                              capture;
    logic                              final_hs;
    logic [ROWS*COLS*WIDTH-1:0]        bank_q;
    logic [BEAT_ELEMS*WIDTH-1:0]       beat_slice;

    // flag_q resets low, so a flag already high at reset release reads as a rise.
    assign rise = calc_done_flag & ~flag_q;

    // Handshake: a beat transfers on any rising edge where out_valid and
    // out_ready are both high. out_valid depends only on registered state,
    // never on out_ready, and once raised the beat (data, row, col_beat,
    // last) holds until it transfers.
    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        capture  = 1'b0;
        final_hs = 1'b0;
        case (state_q)
            NDP_DRAIN_IDLE: begin
                if (rise) begin
                    capture = 1'b1;
                    b_d     = '0;
                    state_d = NDP_DRAIN_DRAIN;
                end
            end
            NDP_DRAIN_DRAIN: begin
                if (out_ready) begin
                    if (b_q == LAST_B) begin
                        final_hs = 1'b1;
                        state_d  = NDP_DRAIN_IDLE;
                    end else begin
                        b_d = b_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = NDP_DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= NDP_DRAIN_IDLE;
            b_q     <= '0;
            flag_q  <= 1'b0;
            clear_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            flag_q  <= calc_done_flag;
            clear_q <= final_hs;
            // A rise while draining (even on the final handshake) is lost.
            if (rise && state_q == NDP_DRAIN_DRAIN) begin
                err_q <= 1'b1;
            end
        end
    end

    // Capture bank is data-only storage; it is written only from IDLE, so it
    // stays frozen for the whole drain and needs no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            bank_q <= in_c;
        end
    end

    ndp_beat_mux #(
        .WIDTH      (WIDTH),
        .BEAT_ELEMS (BEAT_ELEMS),
        .TOTAL      (TOTAL)
    ) u_beat_mux (
        .bank     (bank_q),
        .beat_idx (b_q),
        .slice    (beat_slice)
    );

    assign out_valid    = (state_q == NDP_DRAIN_DRAIN);
    assign busy         = out_valid;
    assign out_data     = out_valid ? beat_slice : '0;
    assign out_row      = out_valid ? ROW_W'(int'(b_q) / BPR) : '0;
    assign out_col_beat = out_valid ? CB_W'(int'(b_q) % BPR) : '0;
    assign out_last     = out_valid & (b_q == LAST_B);
    assign ndp_clear    = clear_q;
    assign err_overflow = err_q;
    assign dbg_state    = state_q;

endmodule
